// File: rtl/seq_calculator.sv
// Sequential calculator core: WIDTH-bit accumulator driven by a
// valid/ready command stream. Single-cycle ALU ops; MUL is a
// WIDTH-step shift-add sequence.
module seq_calculator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_operand,
  output logic [WIDTH-1:0] result,
  output logic             res_valid,
  output logic             busy,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_ovf
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {S_IDLE, S_MUL} state_e;

  localparam logic [2:0] OP_LOAD = 3'd0, OP_ADD = 3'd1, OP_SUB = 3'd2,
                         OP_MUL  = 3'd3, OP_AND = 3'd4, OP_OR  = 3'd5,
                         OP_XOR  = 3'd6, OP_CLR = 3'd7;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     mb_q, mb_d;      // multiplier, consumed LSB first
  logic [2*WIDTH-1:0]   ma_q, ma_d;      // multiplicand, shifted left each step
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d;
  logic                 rv_q, rv_d;

  logic                 accept;
  logic [WIDTH:0]       sum, diff;
  logic [2*WIDTH-1:0]   step_prod;
  logic                 last_step;

  assign in_ready   = (state_q == S_IDLE) && !rst;
  assign accept     = in_valid && in_ready;
  assign result     = acc_q;
  assign res_valid  = rv_q;
  assign busy       = (state_q == S_MUL);
  assign flag_zero  = zero_q;
  assign flag_carry = carry_q;
  assign flag_ovf   = ovf_q;

  assign sum       = {1'b0, acc_q} + {1'b0, in_operand};
  assign diff      = {1'b0, acc_q} - {1'b0, in_operand};
  assign step_prod = prod_q + (mb_q[0] ? ma_q : '0);
  assign last_step = (cnt_q == CW'(WIDTH - 1));

  // Next-state, ALU and multiply sequencing
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mb_d    = mb_q;
    ma_d    = ma_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    rv_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (in_op == OP_MUL) begin
            state_d = S_MUL;
            ma_d    = {{WIDTH{1'b0}}, acc_q};
            mb_d    = in_operand;
            prod_d  = '0;
            cnt_d   = '0;
          end else begin
            carry_d = 1'b0;
            ovf_d   = 1'b0;
            rv_d    = 1'b1;
            case (in_op)
              OP_LOAD: acc_d = in_operand;
              OP_ADD: begin
                acc_d   = sum[WIDTH-1:0];
                carry_d = sum[WIDTH];
                ovf_d   = (acc_q[WIDTH-1] == in_operand[WIDTH-1]) &&
                          (sum[WIDTH-1] != acc_q[WIDTH-1]);
              end
              OP_SUB: begin
                acc_d   = diff[WIDTH-1:0];
                carry_d = diff[WIDTH];   // borrow: A < B unsigned
                ovf_d   = (acc_q[WIDTH-1] != in_operand[WIDTH-1]) &&
                          (diff[WIDTH-1] != acc_q[WIDTH-1]);
              end
              OP_AND:  acc_d = acc_q & in_operand;
              OP_OR:   acc_d = acc_q | in_operand;
              OP_XOR:  acc_d = acc_q ^ in_operand;
              OP_CLR:  acc_d = '0;
              default: acc_d = acc_q;
            endcase
            zero_d = (acc_d == '0);
          end
        end
      end
      S_MUL: begin
        prod_d = step_prod;
        ma_d   = ma_q << 1;
        mb_d   = mb_q >> 1;
        cnt_d  = cnt_q + CW'(1);
        if (last_step) begin
          // Final step folds straight into the accumulator
          state_d = S_IDLE;
          cnt_d   = '0;
          acc_d   = step_prod[WIDTH-1:0];
          zero_d  = (step_prod[WIDTH-1:0] == '0);
          carry_d = 1'b0;
          ovf_d   = |step_prod[2*WIDTH-1:WIDTH];
          rv_d    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any multiply in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      mb_q    <= '0;
      ma_q    <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mb_q    <= mb_d;
      ma_q    <= ma_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      rv_q    <= rv_d;
    end
  end

endmodule

// File: tb/tb_seq_calculator.sv
// Directed bench for seq_calculator: WIDTH=8 instance for most
// scenarios, WIDTH=16 instance for the wide multiply.
module tb_seq_calculator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // WIDTH=8 instance
  logic       rst, in_valid, in_ready, res_valid, busy;
  logic [2:0] in_op;
  logic [7:0] in_operand, result;
  logic       flag_zero, flag_carry, flag_ovf;
  logic [2:0] fl;
  assign fl = {flag_zero, flag_carry, flag_ovf};

  seq_calculator #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_operand(in_operand), .result(result),
    .res_valid(res_valid), .busy(busy), .flag_zero(flag_zero),
    .flag_carry(flag_carry), .flag_ovf(flag_ovf));

  // WIDTH=16 instance
  logic        rst16, iv16, rdy16, rv16, busy16;
  logic [2:0]  op16;
  logic [15:0] opd16, res16;
  logic        z16, c16, o16;

  seq_calculator #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst16), .in_valid(iv16), .in_ready(rdy16),
    .in_op(op16), .in_operand(opd16), .result(res16),
    .res_valid(rv16), .busy(busy16), .flag_zero(z16),
    .flag_carry(c16), .flag_ovf(o16));

  // Drive one command; returns #1 after its accept edge
  task automatic send(input logic [2:0] op, input logic [7:0] b);
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_operand = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    // reset coinciding with a valid command: nothing accepted
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in_op = 3'd0; in_operand = 8'd55;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", in_ready); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if (result !== 8'd0) begin bad++; $display("FAIL rst_result got=%0d exp=0", result); end
    total++; if (fl !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b exp=000", fl); end
    total++; if ({res_valid, busy} !== 2'b00) begin bad++; $display("FAIL rst_rv_busy got=%b exp=00", {res_valid, busy}); end
    @(negedge clk); rst = 1'b0; #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'd0; in_operand = 8'd200;
    @(posedge clk); #1;
    total++; if (res_valid !== 1'b1 || result !== 8'd200) begin bad++; $display("FAIL b2b_load got=%0d rv=%b exp=200 rv=1", result, res_valid); end
    in_op = 3'd1; in_operand = 8'd100;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if (res_valid !== 1'b1 || result !== 8'd44) begin bad++; $display("FAIL b2b_add got=%0d rv=%b exp=44 rv=1", result, res_valid); end
    total++; if (fl !== 3'b010) begin bad++; $display("FAIL b2b_add_flags got=%b exp=010", fl); end
    @(posedge clk); #1;
    total++; if (res_valid !== 1'b0 || result !== 8'd44) begin bad++; $display("FAIL b2b_strobe got rv=%b res=%0d exp rv=0 res=44", res_valid, result); end
  endtask

  task automatic test_arith_flags;
    send(3'd0, 8'd100); send(3'd1, 8'd50);
    total++; if (result !== 8'd150 || fl !== 3'b001) begin bad++; $display("FAIL add_ovf got=%0d fl=%b exp=150 fl=001", result, fl); end
    send(3'd0, 8'd5); send(3'd2, 8'd7);
    total++; if (result !== 8'd254 || fl !== 3'b010) begin bad++; $display("FAIL sub_borrow got=%0d fl=%b exp=254 fl=010", result, fl); end
    send(3'd0, 8'h80); send(3'd2, 8'd1);
    total++; if (result !== 8'h7F || fl !== 3'b001) begin bad++; $display("FAIL sub_ovf got=%h fl=%b exp=7f fl=001", result, fl); end
    send(3'd0, 8'd10); send(3'd2, 8'd10);
    total++; if (result !== 8'd0 || fl !== 3'b100) begin bad++; $display("FAIL sub_zero got=%0d fl=%b exp=0 fl=100", result, fl); end
  endtask

  task automatic test_mul;
    int n;
    logic stall_ok;
    send(3'd0, 8'd12); send(3'd3, 8'd11);
    n = 0; stall_ok = 1'b1;
    while (res_valid !== 1'b1 && n < 40) begin
      if (busy !== 1'b1 || in_ready !== 1'b0) stall_ok = 1'b0;
      @(posedge clk); #1; n++;
    end
    total++; if (stall_ok !== 1'b1) begin bad++; $display("FAIL mul_busy got=%b exp=1", stall_ok); end
    total++; if (n !== 8) begin bad++; $display("FAIL mul_latency got=%0d exp=8", n); end
    total++; if (result !== 8'd132 || fl !== 3'b000) begin bad++; $display("FAIL mul_12x11 got=%0d fl=%b exp=132 fl=000", result, fl); end
    total++; if (busy !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL mul_done got busy=%b rdy=%b exp 0 1", busy, in_ready); end
    @(posedge clk); #1;
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL mul_strobe got=%b exp=0", res_valid); end
    send(3'd0, 8'd20); send(3'd3, 8'd20);
    n = 0;
    while (res_valid !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    total++; if (n !== 8 || result !== 8'h90 || fl !== 3'b001) begin bad++; $display("FAIL mul_20x20 got=%h fl=%b n=%0d exp=90 fl=001 n=8", result, fl, n); end
    // zero multiplicand still runs the full sequence
    send(3'd7, 8'd0); send(3'd3, 8'd7);
    n = 0;
    while (res_valid !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    total++; if (n !== 8 || result !== 8'd0 || fl !== 3'b100) begin bad++; $display("FAIL mul_zero got=%0d fl=%b n=%0d exp=0 fl=100 n=8", result, fl, n); end
  endtask

  task automatic test_hold_during_mul;
    int n;
    send(3'd0, 8'd3);
    @(negedge clk);
    in_valid = 1'b1; in_op = 3'd3; in_operand = 8'd5;
    @(posedge clk); #1;
    in_op = 3'd7; in_operand = 8'd0;   // CLR held pending
    n = 0;
    while (res_valid !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    total++; if (n !== 8 || result !== 8'd15) begin bad++; $display("FAIL hold_mul got=%0d n=%0d exp=15 n=8", result, n); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL hold_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if (res_valid !== 1'b1 || result !== 8'd0 || fl !== 3'b100) begin bad++; $display("FAIL hold_clr got=%0d rv=%b fl=%b exp=0 rv=1 fl=100", result, res_valid, fl); end
  endtask

  task automatic test_logic;
    send(3'd0, 8'hFF); send(3'd6, 8'hFF);
    total++; if (result !== 8'h00 || fl !== 3'b100) begin bad++; $display("FAIL xor got=%h fl=%b exp=00 fl=100", result, fl); end
    send(3'd5, 8'h0F); send(3'd4, 8'h3C);
    total++; if (result !== 8'h0C || fl !== 3'b000) begin bad++; $display("FAIL or_and got=%h fl=%b exp=0c fl=000", result, fl); end
    send(3'd0, 8'd200); send(3'd1, 8'd100); send(3'd4, 8'h3C);
    total++; if (result !== 8'h2C || fl !== 3'b000) begin bad++; $display("FAIL and_clr_carry got=%h fl=%b exp=2c fl=000", result, fl); end
  endtask

  task automatic test_mul_reset;
    logic saw;
    send(3'd0, 8'h80); send(3'd2, 8'd1);   // leaves ovf=1
    send(3'd3, 8'd3);
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    total++; if (result !== 8'd0 || fl !== 3'b000) begin bad++; $display("FAIL mulrst_state got=%0d fl=%b exp=0 fl=000", result, fl); end
    total++; if (busy !== 1'b0 || res_valid !== 1'b0) begin bad++; $display("FAIL mulrst_busy got busy=%b rv=%b exp 0 0", busy, res_valid); end
    rst = 1'b0; #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mulrst_ready got=%b exp=1", in_ready); end
    saw = 1'b0;
    repeat (12) begin @(posedge clk); #1; if (res_valid === 1'b1) saw = 1'b1; end
    total++; if (saw !== 1'b0 || result !== 8'd0) begin bad++; $display("FAIL mulrst_no_pulse got rv_seen=%b res=%0d exp 0 0", saw, result); end
  endtask

  task automatic test_w16;
    int n;
    @(negedge clk);
    rst16 = 1'b0; iv16 = 1'b1; op16 = 3'd0; opd16 = 16'd300;
    @(posedge clk); #1;
    op16 = 3'd3; opd16 = 16'd200;
    @(posedge clk); #1;
    iv16 = 1'b0;
    n = 0;
    while (rv16 !== 1'b1 && n < 60) begin @(posedge clk); #1; n++; end
    total++; if (n !== 16) begin bad++; $display("FAIL w16_latency got=%0d exp=16", n); end
    total++; if (res16 !== 16'd60000 || {z16, c16, o16} !== 3'b000) begin bad++; $display("FAIL w16_mul got=%0d fl=%b exp=60000 fl=000", res16, {z16, c16, o16}); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = 3'd0; in_operand = 8'd0;
    rst16 = 1'b1; iv16 = 1'b0; op16 = 3'd0; opd16 = 16'd0;
    test_reset;
    test_back_to_back;
    test_arith_flags;
    test_mul;
    test_hold_during_mul;
    test_logic;
    test_mul_reset;
    test_w16;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
